// File: rtl/impl_window_checker_pkg.sv
// Shared types and helpers for the windowed-implication checker.
package impl_chk_pkg;

  // Widest fail counter a lane can export through the status record.
  localparam int unsigned CNT_MAX_W = 16;

  // Width needed to hold a window bound in the range 0..max_dly.
  function automatic int unsigned dly_w(input int unsigned max_dly);
    return $clog2(max_dly + 1);
  endfunction

  // Per-channel status exported by each lane.
  typedef struct packed {
    logic                 pass;
    logic                 fail;
    logic                 sticky;
    logic [CNT_MAX_W-1:0] cnt;
  } lane_status_t;

endpackage

// File: rtl/impl_window_checker_lane.sv
// One checker channel: pending-attempt vector, window evaluation,
// registered pass/fail pulses, sticky error flag and saturating counter.
module impl_chk_lane
  import impl_chk_pkg::*;
#(
  parameter int unsigned MAX_DLY = 7,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned DLY_W   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cons,
  input  logic             clr,
  input  logic             flush,
  input  logic [DLY_W-1:0] cfg_min,
  input  logic [DLY_W-1:0] cfg_max,
  output lane_status_t     status,
  output logic             busy
);

  // r_pend[k]: attempt that will be age k+1 at the next evaluation.
  logic [MAX_DLY-1:0] r_pend;
  logic               r_pass;
  logic               r_fail;
  logic               r_sticky;
  logic [CNT_W-1:0]   r_cnt;

  logic [MAX_DLY:0]   w_age;
  logic [MAX_DLY:0]   w_ge_min;
  logic [MAX_DLY:0]   w_eq_max;
  logic [MAX_DLY:0]   w_le_max;
  logic [MAX_DLY:0]   w_pass;
  logic [MAX_DLY:0]   w_fail;
  logic [MAX_DLY-1:0] w_surv;
  logic               w_fail_now;

  // Evaluate every live attempt against the window using shift-built masks.
  always_comb begin
    w_age    = {r_pend, start};
    w_ge_min = '1;
    w_ge_min = w_ge_min << cfg_min;
    w_eq_max = (MAX_DLY + 1)'(1);
    w_eq_max = w_eq_max << cfg_max;
    w_le_max = w_eq_max | (w_eq_max - (MAX_DLY + 1)'(1));
    w_pass   = w_age & w_ge_min & w_le_max & {(MAX_DLY + 1){cons}};
    w_fail   = w_age & w_eq_max & ~w_pass;
    // Attempts older than max (only possible after a mid-flight config
    // change) are dropped rather than aged forever.
    w_surv   = w_age[MAX_DLY-1:0] & ~w_pass[MAX_DLY-1:0] &
               w_le_max[MAX_DLY-1:0] & ~w_eq_max[MAX_DLY-1:0];
    w_fail_now = ~flush & (|w_fail);
  end

  // Age surviving attempts and register the per-cycle pass/fail pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_pass <= 1'b0;
      r_fail <= 1'b0;
    end else if (flush) begin
      r_pend <= '0;
      r_pass <= 1'b0;
      r_fail <= 1'b0;
    end else begin
      r_pend <= w_surv;
      r_pass <= |w_pass;
      r_fail <= |w_fail;
    end
  end

  // Sticky flag and saturating counter; a same-cycle failure beats clr.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end else if (w_fail_now) begin
      r_sticky <= 1'b1;
      if (clr) begin
        r_cnt <= CNT_W'(1);
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else if (clr) begin
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end
  end

  // Pack the lane status for the top level.
  always_comb begin
    status.pass   = r_pass;
    status.fail   = r_fail;
    status.sticky = r_sticky;
    status.cnt    = CNT_MAX_W'(r_cnt);
    busy          = |r_pend;
  end

endmodule

// File: rtl/impl_window_checker.sv
// Multi-channel runtime monitor for a |-> ##[min:max] b with a shared,
// runtime-programmable window latched while checking is disabled.
module impl_window_checker
  import impl_chk_pkg::*;
#(
  parameter  int unsigned NUM_CH  = 4,
  parameter  int unsigned MAX_DLY = 7,
  parameter  int unsigned CNT_W   = 8,
  localparam int unsigned DLY_W   = dly_w(MAX_DLY)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    clr,
  input  logic [DLY_W-1:0]        cfg_min,
  input  logic [DLY_W-1:0]        cfg_max,
  input  logic [NUM_CH-1:0]       ante,
  input  logic [NUM_CH-1:0]       cons,
  output logic [NUM_CH-1:0]       pass_p,
  output logic [NUM_CH-1:0]       fail_p,
  output logic [NUM_CH-1:0]       err_sticky,
  output logic [NUM_CH*CNT_W-1:0] fail_cnt,
  output logic                    cfg_err,
  output logic                    busy
);

  logic [DLY_W-1:0]  r_min;
  logic [DLY_W-1:0]  r_max;
  logic [31:0]       w_max_ext;
  logic              w_cfg_err;
  logic [NUM_CH-1:0] w_start;
  logic [NUM_CH-1:0] w_busy;
  lane_status_t      w_st [NUM_CH];

  // Window bounds track the cfg ports only while checking is disabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_min <= '0;
      r_max <= '0;
    end else if (!en) begin
      r_min <= cfg_min;
      r_max <= cfg_max;
    end
  end

  // Legality of the latched window and gating of new attempts.
  always_comb begin
    w_max_ext = 32'(r_max);
    w_cfg_err = (r_min > r_max) || (w_max_ext > MAX_DLY);
    w_start   = ante & {NUM_CH{en & ~w_cfg_err}};
    cfg_err   = w_cfg_err;
    busy      = |w_busy;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    impl_chk_lane #(
      .MAX_DLY (MAX_DLY),
      .CNT_W   (CNT_W),
      .DLY_W   (DLY_W)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (w_start[g]),
      .cons    (cons[g]),
      .clr     (clr),
      .flush   (w_cfg_err),
      .cfg_min (r_min),
      .cfg_max (r_max),
      .status  (w_st[g]),
      .busy    (w_busy[g])
    );

    assign pass_p[g]                  = w_st[g].pass;
    assign fail_p[g]                  = w_st[g].fail;
    assign err_sticky[g]              = w_st[g].sticky;
    assign fail_cnt[g*CNT_W +: CNT_W] = CNT_W'(w_st[g].cnt);
  end

endmodule

// File: tb/tb_impl_window_checker.sv
// Directed, table-driven bench for impl_window_checker (4 channels,
// MAX_DLY=7, 2-bit counters so saturation is reachable quickly).
module tb_impl_window_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic [2:0] cfg_min;
  logic [2:0] cfg_max;
  logic [3:0] ante;
  logic [3:0] cons;
  logic [3:0] pass_p;
  logic [3:0] fail_p;
  logic [3:0] err_sticky;
  logic [7:0] fail_cnt;
  logic       cfg_err;
  logic       busy;

  int total = 0;
  int bad   = 0;

  impl_window_checker #(
    .NUM_CH  (4),
    .MAX_DLY (7),
    .CNT_W   (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .clr        (clr),
    .cfg_min    (cfg_min),
    .cfg_max    (cfg_max),
    .ante       (ante),
    .cons       (cons),
    .pass_p     (pass_p),
    .fail_p     (fail_p),
    .err_sticky (err_sticky),
    .fail_cnt   (fail_cnt),
    .cfg_err    (cfg_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       clr;
    logic [3:0] ante;
    logic [3:0] cons;
    logic [3:0] pass;
    logic [3:0] fail;
    logic [3:0] sticky;
    logic [7:0] cnt;
    logic       busy;
  } vec_t;

  vec_t tbl [12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic setcfg(input logic [2:0] mn, input logic [2:0] mx);
    en = 1'b0; ante = '0; cons = '0; clr = 1'b0;
    cfg_min = mn; cfg_max = mx;
    step();
  endtask

  // Channel-0 sequence; bit j of each mask is cycle j.
  task automatic seq(input string nm, input int n, input logic [7:0] en_s,
                     input logic [7:0] ante_s, input logic [7:0] cons_s,
                     input logic [7:0] pass_s, input logic [7:0] fail_s,
                     input logic [7:0] busy_s);
    for (int j = 0; j < n; j++) begin
      en   = en_s[j];
      ante = {3'b000, ante_s[j]};
      cons = {3'b000, cons_s[j]};
      step();
      chk($sformatf("%s_pass%0d", nm, j), 32'(pass_p), {31'd0, pass_s[j]});
      chk($sformatf("%s_fail%0d", nm, j), 32'(fail_p), {31'd0, fail_s[j]});
      chk($sformatf("%s_busy%0d", nm, j), 32'(busy),   {31'd0, busy_s[j]});
    end
    ante = '0; cons = '0;
  endtask

  initial begin
    //          en    clr   ante     cons     pass     fail     sticky   cnt    busy
    tbl[0]  = '{1'b1, 1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 8'h01, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 4'b1110, 4'b1010, 4'b1010, 4'b0100, 4'b0101, 8'h11, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0101, 8'h11, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 8'h01, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 8'h02, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 8'h03, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 8'h03, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 8'h03, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 8'h03, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b0};

    rst_n = 1'b0; en = 1'b0; clr = 1'b0;
    cfg_min = '0; cfg_max = '0; ante = '0; cons = '0;
    step();
    step();
    chk("rst_pass",   32'(pass_p),     32'd0);
    chk("rst_fail",   32'(fail_p),     32'd0);
    chk("rst_sticky", 32'(err_sticky), 32'd0);
    chk("rst_cnt",    32'(fail_cnt),   32'd0);
    chk("rst_cfgerr", 32'(cfg_err),    32'd0);
    chk("rst_busy",   32'(busy),       32'd0);
    rst_n = 1'b1;

    // Overlapped mode (min=max=0): one cycle per table entry.
    for (int i = 0; i < 12; i++) begin
      en = tbl[i].en; clr = tbl[i].clr; ante = tbl[i].ante; cons = tbl[i].cons;
      step();
      chk($sformatf("tbl%0d_pass", i),   32'(pass_p),     32'(tbl[i].pass));
      chk($sformatf("tbl%0d_fail", i),   32'(fail_p),     32'(tbl[i].fail));
      chk($sformatf("tbl%0d_sticky", i), 32'(err_sticky), 32'(tbl[i].sticky));
      chk($sformatf("tbl%0d_cnt", i),    32'(fail_cnt),   32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_busy", i),   32'(busy),       32'(tbl[i].busy));
    end
    clr = 1'b0;

    // Window [2:4].
    setcfg(3'd2, 3'd4);
    chk("w24_cfgerr", 32'(cfg_err), 32'd0);
    seq("w24_cons3",  4, 8'hFF, 8'b00001, 8'b01000, 8'b01000, 8'b00000, 8'b00111);
    seq("w24_early",  5, 8'hFF, 8'b00001, 8'b00010, 8'b00000, 8'b10000, 8'b01111);
    seq("w24_atmin",  3, 8'hFF, 8'b00001, 8'b00100, 8'b00100, 8'b00000, 8'b00011);
    seq("w24_atmax",  5, 8'hFF, 8'b00001, 8'b10000, 8'b10000, 8'b00000, 8'b01111);

    // Window [1:3]: overlapping attempts and enable drop.
    setcfg(3'd1, 3'd3);
    seq("w13_overlap", 4, 8'hFF, 8'b0111,  8'b1000, 8'b1000,  8'b0000,  8'b0111);
    seq("w13_twofail", 5, 8'hFF, 8'b00011, 8'b0000, 8'b00000, 8'b11000, 8'b01111);
    seq("w13_endrop",  4, 8'h01, 8'b0011,  8'b0000, 8'b0000,  8'b1000,  8'b0111);

    // Illegal config flushes a pending attempt and blocks new ones.
    en = 1'b1; ante = 4'b0001; cons = '0;
    step();
    chk("cfg_pend_busy", 32'(busy), 32'd1);
    en = 1'b0; ante = '0; cfg_min = 3'd5; cfg_max = 3'd3;
    step();
    chk("cfg_err_set", 32'(cfg_err), 32'd1);
    chk("cfg_age_busy", 32'(busy), 32'd1);
    step();
    chk("cfg_flush_busy", 32'(busy), 32'd0);
    chk("cfg_flush_fail", 32'(fail_p), 32'd0);
    en = 1'b1; ante = 4'b0001; cons = 4'b0001;
    step();
    chk("cfg_blk_pass", 32'(pass_p), 32'd0);
    chk("cfg_blk_fail", 32'(fail_p), 32'd0);
    chk("cfg_blk_busy", 32'(busy), 32'd0);
    ante = '0; cons = '0; cfg_min = 3'd0; cfg_max = 3'd0;
    step();
    chk("cfg_locked", 32'(cfg_err), 32'd1);

    // Reset in the middle of a [0:4] window.
    setcfg(3'd0, 3'd4);
    chk("rmw_cfgerr", 32'(cfg_err), 32'd0);
    en = 1'b1; ante = 4'b0001;
    step();
    chk("rmw_busy0", 32'(busy), 32'd1);
    ante = '0;
    step();
    rst_n = 1'b0;
    step();
    chk("rmw_pass",   32'(pass_p),     32'd0);
    chk("rmw_fail",   32'(fail_p),     32'd0);
    chk("rmw_sticky", 32'(err_sticky), 32'd0);
    chk("rmw_cnt",    32'(fail_cnt),   32'd0);
    chk("rmw_cfgerr", 32'(cfg_err),    32'd0);
    chk("rmw_busy",   32'(busy),       32'd0);
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      step();
      chk($sformatf("rmw_after_fail%0d", j), 32'(fail_p), 32'd0);
      chk($sformatf("rmw_after_busy%0d", j), 32'(busy),   32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/impl_window_checker.md
Name: impl_window_checker

Overview:
- Synthesizable runtime monitor that generalises a single overlapped implication check (a |-> b) into NUM_CH independent channels.
- Each channel checks a windowed implication: a |-> ##[min:max] b, with min and max programmable at runtime.
- Overlapping attempts are tracked independently, as in SVA semantics.
- Used in silicon and emulation builds where SVA is unavailable; reports per-channel pass/fail pulses, sticky error flags and saturating fail counters.

Parameters:
- NUM_CH, 4, number of independent channels.
- MAX_DLY, 7, largest supported window bound in cycles (≥1).
- CNT_W, 8, width of each per-channel fail counter.
- DLY_W, $clog2(MAX_DLY+1), width of window configuration fields (derived, not overridable).

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
- en  in  1  checking enable; no new attempts start while low.
- clr  in  1  synchronous clear of sticky flags and counters.
- cfg_min  in  DLY_W  window lower bound; latched only while en=0.
- cfg_max  in  DLY_W  window upper bound; latched only while en=0.
- ante  in  NUM_CH  per-channel antecedent (a).
- cons  in  NUM_CH  per-channel consequent (b).
- pass_p  out  NUM_CH  1-cycle pulse: ≥1 attempt passed this evaluation.
- fail_p  out  NUM_CH  1-cycle pulse: ≥1 attempt failed this evaluation.
- err_sticky  out  NUM_CH  set on any fail; held until clr or reset.
- fail_cnt  out  NUM_CH*CNT_W  per-channel saturating fail count, channel 0 in LSBs.
- cfg_err  out  1  latched configuration is illegal.
- busy  out  1  any attempt pending on any channel.

Behaviour:
- Reset (rst_n=0 at posedge): all outputs 0; pending vectors cleared; latched min=0 and max=0 (overlapped mode). Reset mid-attempt discards every pending attempt without reporting it.
- Config latch: while en=0, each posedge copies cfg_min/cfg_max to internal registers. While en=1, changes on the cfg ports are ignored.
- cfg_err: 1 when latched min>max or max>MAX_DLY. While cfg_err=1, no attempts start and pending attempts are flushed silently.
- Attempt tracking: each channel holds a pending bit-vector pend[0..MAX_DLY]; pend[k]=1 means an attempt whose antecedent was sampled k cycles ago.
- Each posedge with en=1 and ante[i]=1 creates an age-0 attempt, evaluated in the same cycle (overlapped semantics).
- Evaluation per attempt of age k, each cycle:
  - cons[i]=1 and min≤k≤max → pass; attempt retired.
  - k==max and no pass → fail; attempt retired.
  - Otherwise the attempt ages to k+1.
- A single cons pulse passes every attempt currently inside the window. ante=0 creates no attempt (vacuous, no report).
- Outputs are registered: pass_p/fail_p assert on the posedge after the sampling edge (latency 1).
- A channel may pass and fail in the same cycle (different attempts); both pulses assert.
- fail_cnt increments by 1 per cycle with ≥1 failure (not per attempt) and saturates at 2^CNT_W-1.
- en 1→0: pending attempts continue evaluating to completion; only new starts are blocked.
- clr=1 zeroes err_sticky and fail_cnt. A failure in the same cycle as clr wins: err_sticky=1, fail_cnt=1. clr does not affect pending attempts.
- busy = OR of all pend bits after the update.

Decomposition:
- Package impl_chk_pkg: DLY_W helper function, and a typedef of the per-channel status struct {pass, fail, sticky, cnt}.
- Sub-module impl_chk_lane: one channel's pending vector, evaluation, sticky flag and counter. The top level instantiates NUM_CH lanes via generate and owns the config latch, cfg_err and busy.

Test Plan:
- Overlapped mode (min=max=0): ante=1 with cons=1 → pass_p[0]=1 one cycle later. Next cycle ante=1, cons=0 → fail_p[0]=1, err_sticky[0]=1, fail_cnt[0]=1.
- Window min=2, max=4: ante at cycle 10, cons at cycle 13 → pass_p at 14. Separate run with cons only at cycle 11 → fail_p at 15.
- Overlapping attempts, min=1, max=3: ante at cycles 0, 1, 2 and cons at cycle 3 → all three attempts pass; single pass_p at 4, no fail.
- Saturation with CNT_W=2: five failing cycles → fail_cnt[0]=3. clr coincident with a fail → err_sticky=1, fail_cnt=1.
- Config: cfg_min=5, cfg_max=3 with en=0 → cfg_err=1 and ante ignored. Changing cfg while en=1 leaves the latched values unchanged.
- Reset mid-window: ante at cycle 0 (max=4), rst_n=0 at cycle 2 → no fail_p, busy=0, all outputs 0.
